// File: rtl/reset_seq_if.sv
// ---------------------------------------------------------------------------
// reset_seq_if
//   Bundles the request, control and status signals of the staged reset
//   sequencer. clk and reset_n are not part of the bundle; they stay plain
//   ports on the sequencer.
//
//   Signals:
//     sw_rst_req    software reset request (level, sampled on posedge)
//     wdt_expire    watchdog expiry (level, sampled on posedge)
//     hold_in_reset freezes the release sequence while high
//     stage_rst_n   per-domain active-low resets, stage 0 released first
//     all_released  every stage_rst_n bit is 1
//     busy          inverse of all_released
//     rst_cause     cause of last reset: 00 POR, 01 SW, 10 WDT
//
//   Modports:
//     master  the SoC side: drives requests/hold, observes resets/status
//     slave   the sequencer side
// ---------------------------------------------------------------------------
interface reset_seq_if #(
  parameter int NUM_STAGES = 3
);
  logic                  sw_rst_req;
  logic                  wdt_expire;
  logic                  hold_in_reset;
  logic [NUM_STAGES-1:0] stage_rst_n;
  logic                  all_released;
  logic                  busy;
  logic [1:0]            rst_cause;

  modport master (
    output sw_rst_req, wdt_expire, hold_in_reset,
    input  stage_rst_n, all_released, busy, rst_cause
  );

  modport slave (
    input  sw_rst_req, wdt_expire, hold_in_reset,
    output stage_rst_n, all_released, busy, rst_cause
  );
endinterface

// File: rtl/reset_seq.sv
// ---------------------------------------------------------------------------
// reset_seq
//   Staged reset release sequencer. Sits behind the synchronized reset
//   generator and releases NUM_STAGES reset domains in ascending order,
//   STAGE_DELAY cycles apart. A software request or watchdog expiry pulls
//   every domain back into reset for PULSE_LEN cycles and then replays the
//   release sequence. The cause of the most recent reset is recorded.
//
//   Ports:
//     clk      clock, all state on posedge
//     reset_n  asynchronous active-low reset from the reset generator
//     bus      reset_seq_if.slave: requests, hold, stage resets, status
//
//   Parameters:
//     NUM_STAGES   number of reset domains
//     STAGE_DELAY  cycles between successive stage releases (>=1)
//     PULSE_LEN    cycles all stages stay asserted after a request (>=1)
//     CNT_W        counter width, holds max(STAGE_DELAY, PULSE_LEN)-1
// ---------------------------------------------------------------------------
module reset_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_DELAY = 8,
  parameter int PULSE_LEN   = 4,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  reset_seq_if.slave   bus
);

  localparam int K_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [K_W-1:0]   K_LAST     = K_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_WAIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REASSERT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_SW  = 2'b01,
    CAUSE_WDT = 2'b10
  } cause_t;

  state_t                state_q, state_d;
  logic [K_W-1:0]        k_q, k_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  all_rel_q, all_rel_d;
  cause_t                cause_q, cause_d;

  logic                  req;

  assign req = bus.sw_rst_req | bus.wdt_expire;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    all_rel_d = all_rel_q;
    cause_d   = cause_q;

    unique case (state_q)
      ST_WAIT: begin
        if (!bus.hold_in_reset) begin
          if (cnt_q == STAGE_LAST) begin
            stage_d[k_q] = 1'b1;
            cnt_d        = '0;
            k_d          = k_q + K_W'(1);
            if (k_q == K_LAST) begin
              state_d   = ST_RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RUN: begin
        // Outputs hold; only a request (handled below) leaves this state.
      end

      ST_REASSERT: begin
        // Requests and hold are ignored until the pulse has completed.
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // Unreachable encoding: fall back into a clean reassert.
        state_d   = ST_REASSERT;
        cnt_d     = '0;
        k_d       = '0;
        stage_d   = '0;
        all_rel_d = 1'b0;
      end
    endcase

    // A request in WAIT or RUN overrides the sequencing above; assertion is
    // always simultaneous across all stages. Watchdog wins on a tie.
    if ((state_q == ST_WAIT || state_q == ST_RUN) && req) begin
      state_d   = ST_REASSERT;
      cnt_d     = '0;
      k_d       = '0;
      stage_d   = '0;
      all_rel_d = 1'b0;
      cause_d   = bus.wdt_expire ? CAUSE_WDT : CAUSE_SW;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_WAIT;
      k_q       <= '0;
      cnt_q     <= '0;
      stage_q   <= '0;
      all_rel_q <= 1'b0;
      cause_q   <= CAUSE_POR;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q   <= state_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      all_rel_q <= all_rel_d;
      cause_q   <= cause_d;
    end
  end

  // Outputs come straight from registers; busy is a pure inversion of one.
  assign bus.stage_rst_n  = stage_q;
  assign bus.all_released = all_rel_q;
  assign bus.busy         = ~all_rel_q;
  assign bus.rst_cause    = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_reset_seq
//   Directed bench for reset_seq with the default parameters. The stimulus
//   process drives requests/resets and pushes the expected output changes,
//   each tagged with the posedge after which it must appear. A monitor
//   samples the outputs on every negedge; whenever they change it pops the
//   oldest expectation and compares values and edge number.
// ---------------------------------------------------------------------------
module tb_reset_seq;

  localparam int NUM_STAGES  = 3;
  localparam int STAGE_DELAY = 8;
  localparam int PULSE_LEN   = 4;
  localparam int CNT_W       = 8;

  typedef struct {
    int          edge_n;   // -1: edge number not checked
    logic [2:0]  stage;
    logic        all_rel;
    logic        busy;
    logic [1:0]  cause;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   ec = 0;            // posedges seen so far

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];

  reset_seq_if #(.NUM_STAGES(NUM_STAGES)) bus ();

  reset_seq #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_DELAY(STAGE_DELAY),
    .PULSE_LEN  (PULSE_LEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec++;

  // Bench model of the outputs: all_released and busy follow the stages.
  function automatic void push(input int e, input logic [2:0] s,
                               input logic [1:0] c, input string tag);
    exp_t x;
    x.edge_n  = e;
    x.stage   = s;
    x.all_rel = &s;
    x.busy    = ~(&s);
    x.cause   = c;
    x.tag     = tag;
    q.push_back(x);
  endfunction

  // Monitor: compare on every observed output change.
  logic [7:0] prev = 'x;
  always @(negedge clk) begin
    logic [7:0] cur;
    exp_t       e;
    cur = {bus.stage_rst_n, bus.all_released, bus.busy, bus.rst_cause};
    if (cur !== prev) begin
      prev = cur;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: edge %0d got stage %b all %b busy %b cause %b, expected no change",
                 ec, bus.stage_rst_n, bus.all_released, bus.busy, bus.rst_cause);
      end else begin
        e = q.pop_front();
        if ((e.edge_n >= 0 && e.edge_n != ec) ||
            bus.stage_rst_n !== e.stage || bus.all_released !== e.all_rel ||
            bus.busy !== e.busy || bus.rst_cause !== e.cause) begin
          miscompares++;
          $display("FAIL %s: got edge %0d stage %b all %b busy %b cause %b, expected edge %0d stage %b all %b busy %b cause %b",
                   e.tag, ec, bus.stage_rst_n, bus.all_released, bus.busy, bus.rst_cause,
                   e.edge_n, e.stage, e.all_rel, e.busy, e.cause);
        end
      end
    end
  end

  // Advance to 2 time units after posedge number t.
  task automatic wait_ec(input int t);
    while (ec < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Hold request lines high across exactly one posedge; e is that edge.
  task automatic pulse_req(input logic sw, input logic wdt, output int e);
    bus.sw_rst_req = sw;
    bus.wdt_expire = wdt;
    e = ec + 1;
    @(posedge clk);
    #2;
    bus.sw_rst_req = 1'b0;
    bus.wdt_expire = 1'b0;
  endtask

  // Assert reset_n mid-cycle; outputs must change before the next posedge.
  task automatic assert_reset(input string tag);
    @(posedge clk);
    #2;
    push(ec, 3'b000, 2'b00, tag);
    reset_n = 1'b0;
  endtask

  // Release reset_n after one more posedge; b is the last edge with reset low.
  task automatic release_reset(output int b);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    b = ec;
  endtask

  // Expected full release sequence after the stage-0 countdown starts at t0.
  task automatic push_release(input int t0, input logic [1:0] c, input string tag);
    push(t0 + STAGE_DELAY,     3'b001, c, {tag, "_s0"});
    push(t0 + 2 * STAGE_DELAY, 3'b011, c, {tag, "_s1"});
    push(t0 + 3 * STAGE_DELAY, 3'b111, c, {tag, "_s2"});
  endtask

  initial begin
    int b;
    int e;
    int dummy;
    bus.sw_rst_req    = 1'b0;
    bus.wdt_expire    = 1'b0;
    bus.hold_in_reset = 1'b0;

    // POR: reset low for 5 posedges, then the plain release timing.
    #1;
    push(-1, 3'b000, 2'b00, "por_reset_state");
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b1;
    b = ec;
    push_release(b, 2'b00, "por");
    wait_ec(b + 30);

    // Hold for exactly 10 posedges starting at edge 4 of a fresh POR.
    assert_reset("hold_reset");
    release_reset(b);
    push(b + 18, 3'b001, 2'b00, "hold_s0");
    push(b + 26, 3'b011, 2'b00, "hold_s1");
    push(b + 34, 3'b111, 2'b00, "hold_s2");
    wait_ec(b + 3);
    bus.hold_in_reset = 1'b1;
    wait_ec(b + 13);
    bus.hold_in_reset = 1'b0;
    wait_ec(b + 40);

    // SW reset from RUN with a second request during REASSERT.
    bus.hold_in_reset = 1'b1;      // ignored in RUN
    push(ec + 1, 3'b000, 2'b01, "sw_assert");
    pulse_req(1'b1, 1'b0, e);
    bus.hold_in_reset = 1'b0;
    push_release(e + PULSE_LEN, 2'b01, "sw");
    wait_ec(e + 1);
    pulse_req(1'b1, 1'b0, dummy);  // lands on edge e+2, must be ignored
    wait_ec(e + 32);

    // Simultaneous sw and wdt: watchdog recorded, same timing.
    push(ec + 1, 3'b000, 2'b10, "both_assert");
    pulse_req(1'b1, 1'b1, e);
    push_release(e + PULSE_LEN, 2'b10, "both");
    wait_ec(e + 32);

    // Request right after stage 0 is released mid-WAIT.
    push(ec + 1, 3'b000, 2'b01, "midwait_first");
    pulse_req(1'b1, 1'b0, e);
    push(e + 12, 3'b001, 2'b01, "midwait_s0");
    wait_ec(e + 12);
    push(ec + 1, 3'b000, 2'b01, "midwait_reassert");
    pulse_req(1'b1, 1'b0, e);
    push_release(e + PULSE_LEN, 2'b01, "midwait_restart");
    wait_ec(e + 32);

    // Watchdog reset, then reset_n low for one cycle mid-REASSERT.
    push(ec + 1, 3'b000, 2'b10, "wdt_assert");
    pulse_req(1'b0, 1'b1, e);
    assert_reset("wdt_por_reset");
    release_reset(b);
    push_release(b, 2'b00, "wdt_por");
    wait_ec(b + 30);

    // Every pushed expectation must have been observed.
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_changes: got %0d unobserved expectations, expected 0 (first %s)",
               q.size(), q[0].tag);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by time %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Staged reset release sequencer placed directly downstream of the synchronized active-low reset generator.
- Takes the clean `reset_n` and releases `NUM_STAGES` reset domains one after another, in the testbench/SoC top, with a programmable spacing between releases (e.g. memories, then bus, then core).
- Also re-asserts all domains on a software reset request or watchdog expiry, and records the cause of the last reset.

Parameters:
- NUM_STAGES, 3, number of reset domains; stage 0 is released first.
- STAGE_DELAY, 8, cycles between successive stage releases (>=1).
- PULSE_LEN, 4, cycles all stages stay asserted after a sw/wdt request (>=1).
- CNT_W, 8, counter width; must hold max(STAGE_DELAY, PULSE_LEN)-1.

Ports:
- clk  input  1  clock; all state on posedge.
- reset_n  input  1  asynchronous, active-low reset (from the reset generator).
- sw_rst_req  input  1  software reset request, level sampled on posedge.
- wdt_expire  input  1  watchdog expiry, level sampled on posedge.
- hold_in_reset  input  1  freezes the release sequence while high.
- stage_rst_n  output  NUM_STAGES  per-domain active-low resets, registered.
- all_released  output  1  high when every stage_rst_n bit is 1.
- busy  output  1  equals ~all_released.
- rst_cause  output  2  cause of last reset: 00 POR, 01 SW, 10 WDT.

Behaviour:
- Async reset (reset_n=0), effective immediately:
  - stage_rst_n=0, all_released=0, busy=1, rst_cause=00.
  - state=WAIT, stage index k=0, cnt=0.
- States: WAIT, RUN, REASSERT. All outputs are registered and change only on posedge, except on async reset.
- WAIT:
  - Each posedge with hold_in_reset=0: cnt++.
  - At the edge where cnt==STAGE_DELAY-1: stage_rst_n[k] set to 1, cnt=0, k++.
  - When the last stage is released: go to RUN; all_released rises on that same edge.
- WAIT, hold_in_reset=1: cnt and k are frozen, and already-released stages stay released.
- Timing: stage i rises after posedge number (i+1)*STAGE_DELAY, counted from the first posedge with reset_n=1 (no hold).
- RUN: outputs are stable and hold_in_reset is ignored.
- Request in WAIT or RUN (sw_rst_req or wdt_expire high at a posedge):
  - On that edge: all stage_rst_n=0, all_released=0, go to REASSERT, cnt=0, k=0.
  - rst_cause=10 if wdt_expire=1 (wdt wins on simultaneous requests), else 01.
- REASSERT:
  - All requests and hold_in_reset are ignored.
  - After PULSE_LEN posedges, go to WAIT with cnt=0.
  - Stage 0 then rises PULSE_LEN+STAGE_DELAY edges after the request edge.
- A request still high on the first edge in WAIT retriggers REASSERT. Sources must deliver pulses or clear their request once they see stage_rst_n low.
- Reset release order is strict ascending and assertion is always simultaneous across all stages.
- rst_cause is held until the next request or async reset.
- reset_n low in any state, mid-sequence or mid-REASSERT: immediate return to the reset values above. rst_cause becomes 00 (the previous cause is lost).
- No combinational path from inputs to outputs.

Test Plan (defaults NUM_STAGES=3, STAGE_DELAY=8, PULSE_LEN=4):
- POR: reset_n low 5 cycles, then high -> stage_rst_n=000 until edge 8; 001 after edge 8, 011 after edge 16, 111 and all_released=1 after edge 24; rst_cause=00, busy falls with all_released.
- Hold: hold_in_reset high for exactly 10 posedges starting at edge 4 -> stage 0 rises after edge 18, stage 2 after edge 34.
- SW reset: 1-cycle sw_rst_req in RUN at edge E -> stage_rst_n=000 after E, 001 after E+12, 111 after E+28; rst_cause=01. A second request at E+2 is ignored.
- Simultaneous sw_rst_req and wdt_expire in RUN -> rst_cause=10, same timing as the SW reset case.
- Request mid-WAIT: sw_rst_req right after stage 0 is released (outputs 001) -> 000 on the next edge, sequence restarts from stage 0.
- reset_n low for 1 cycle mid-REASSERT after a wdt reset -> outputs 000 immediately, rst_cause=00, full POR timing restarts from reset_n release.
